// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART transmitter among
// NUM_REQ byte producers. One word is taken per grant and sent to the
// transmitter. The arbiter then waits for tx_done_tick before it arbitrates again.
// Optional feature macro: UART_ARB_TAG_EN. When defined, each payload is preceded
// by a tag word (TAG_BASE | granted index).
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DataBits = 8,
  parameter int unsigned TAG_BASE = 8'hA0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DataBits-1:0] req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_start,
  output logic [DataBits-1:0]         tx_din,
  input  logic                        tx_done_tick,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  // Elaboration-time parameter sanity checks
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be in 2..16");
  end
  if ((DataBits < 32) && ((TAG_BASE >> DataBits) != 0)) begin : g_bad_tag_base
    $error("uart_tx_arbiter: TAG_BASE does not fit in DataBits");
  end
`ifdef UART_ARB_TAG_EN
  if (DataBits < IdW) begin : g_bad_tag_width
    $error("uart_tx_arbiter: DataBits too narrow to carry the requester index");
  end
`endif

`ifdef UART_ARB_TAG_EN
  typedef enum logic [2:0] {IDLE, TAG_LOAD, TAG_WAIT, LOAD, WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;
`endif

  state_t              state_q, state_d;
  logic [IdW-1:0]      ptr_q, ptr_d;
  logic [DataBits-1:0] word_q, word_d;
  logic [NUM_REQ-1:0]  ready_d;
  logic                start_d;
  logic [DataBits-1:0] din_d;
  logic                busy_d;
  logic [IdW-1:0]      grant_d;

  logic                found;
  logic [IdW-1:0]      win;
  int unsigned         idx;
  logic [DataBits-1:0] win_data;

  // Round-robin search: first valid requester at or after ptr, wrapping at NUM_REQ-1
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = 32'(ptr_q) + off;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found && req_valid[IdW'(idx)]) begin
        found = 1'b1;
        win   = IdW'(idx);
      end
    end
  end

  // Select the winning requester's word
  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win == IdW'(i)) begin
        win_data = req_data[i*DataBits +: DataBits];
      end
    end
  end

  // Next-state and next-output logic; all outputs are registered from these values
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    word_d  = word_q;
    ready_d = '0;
    start_d = 1'b0;
    din_d   = tx_din;
    grant_d = grant_id;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          word_d       = win_data;
          grant_d      = win;
          ready_d[win] = 1'b1;
          ptr_d        = (win == IdW'(NUM_REQ - 1)) ? '0 : win + IdW'(1);
`ifdef UART_ARB_TAG_EN
          state_d      = TAG_LOAD;
`else
          state_d      = LOAD;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      TAG_LOAD: begin
        start_d = 1'b1;
        din_d   = DataBits'(TAG_BASE) | DataBits'(grant_id);
        state_d = TAG_WAIT;
      end
      // A done tick coincident with our own start pulse is a stale tick, never
      // the end of the frame just started; the wait effectively begins a cycle later.
      TAG_WAIT: begin
        if (tx_done_tick && !tx_start) begin
          state_d = LOAD;
        end
      end
`endif
      LOAD: begin
        start_d = 1'b1;
        din_d   = word_q;
        state_d = WAIT;
      end
      // Same stale-tick rule as above: ignore done during the start pulse cycle
      WAIT: begin
        if (tx_done_tick && !tx_start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, pointer, captured word and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      word_q    <= '0;
      req_ready <= '0;
      tx_start  <= 1'b0;
      tx_din    <= '0;
      busy      <= 1'b0;
      grant_id  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      word_q    <= word_d;
      req_ready <= ready_d;
      tx_start  <= start_d;
      tx_din    <= din_d;
      busy      <= busy_d;
      grant_id  <= grant_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (NUM_REQ=4, DataBits=8, TAG_BASE=8'hA0).
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

`ifdef UART_ARB_TAG_EN
  localparam int unsigned FRAMES = 2;
`else
  localparam int unsigned FRAMES = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req_valid = 4'hF;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_din;
  logic        tx_done_tick = 1'b0;
  logic        busy;
  logic [1:0]  grant_id;

  int checks = 0;
  int failures = 0;

  int unsigned exp_grant[$];
  logic [7:0]  exp_tx[$];
  int unsigned mon_g;
  logic [7:0]  mon_d;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .DataBits(8), .TAG_BASE(8'hA0)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_din(tx_din),
    .tx_done_tick(tx_done_tick), .busy(busy), .grant_id(grant_id)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] first_word(input int unsigned id, input logic [7:0] data);
`ifdef UART_ARB_TAG_EN
    return 8'hA0 | 8'(id);
`else
    return data;
`endif
  endfunction

  task automatic expect_word(input int unsigned id, input logic [7:0] data);
    exp_grant.push_back(id);
`ifdef UART_ARB_TAG_EN
    exp_tx.push_back(8'hA0 | 8'(id));
`endif
    exp_tx.push_back(data);
  endtask

  // Monitor: pops expected grants / transmitted words whenever the DUT presents one
  always @(negedge clk) begin
    if (req_ready !== 4'b0) begin
      if (exp_grant.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ready actual=%0h required=0", req_ready);
      end else begin
        mon_g = exp_grant.pop_front();
        check("ready_onehot", 32'(req_ready), 32'(4'b0001 << mon_g));
        check("grant_id", 32'(grant_id), mon_g);
        check("busy_at_ready", 32'(busy), 32'd1);
      end
    end
    if (tx_start !== 1'b0) begin
      if (exp_tx.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_tx_start actual=%0h required=0", tx_start);
      end else begin
        mon_d = exp_tx.pop_front();
        check("tx_din_at_start", 32'(tx_din), 32'(mon_d));
      end
    end
  end

  // Transmitter model: after an already-observed start, wait then pulse done
  task automatic finish_current(input int unsigned hold);
    repeat (hold) @(negedge clk);
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
  endtask

  // Wait (bounded) for n start pulses, completing each frame
  task automatic serve(input int unsigned n, input int unsigned hold);
    bit seen;
    for (int unsigned s = 0; s < n; s++) begin
      seen = 1'b0;
      for (int t = 0; t < 40 && !seen; t++) begin
        @(negedge clk);
        if (tx_start === 1'b1) seen = 1'b1;
      end
      check("tx_start_seen", 32'(seen), 32'd1);
      if (!seen) return;
      finish_current(hold);
    end
  endtask

  // One request: raise valid, confirm ready next cycle, drop valid, serve frames
  task automatic issue(input logic [3:0] valid, input int unsigned id, input logic [7:0] data);
    expect_word(id, data);
    req_valid = valid;
    @(negedge clk);
    check("ready_cycle", 32'(req_ready), 32'(4'b0001 << id));
    req_valid = 4'b0;
    serve(FRAMES, 2);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset held 3 cycles with all requesters valid
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_start", 32'(tx_start), 32'd0);
      check("rst_din", 32'(tx_din), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_grant", 32'(grant_id), 32'd0);
    end
    req_valid = 4'b0;
    reset_n = 1'b1;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    @(negedge clk);

    // Fairness: all valid continuously, grants 0,1,2,3,0,1
    for (int unsigned i = 0; i < 6; i++) expect_word(i % 4, 8'h11 * 8'(i % 4 + 1));
    req_valid = 4'hF;
    for (int i = 0; i < 5; i++) serve(FRAMES, 2);
    @(negedge clk);
    check("fair_last_ready", 32'(req_ready), 32'h2);
    req_valid = 4'b0;
    serve(FRAMES, 2);
    repeat (3) @(negedge clk);
    check("fair_idle_busy", 32'(busy), 32'd0);

    // Single request from requester 2 with exact latency
    req_data[23:16] = 8'h5A;
    expect_word(2, 8'h5A);
    req_valid = 4'b0100;
    @(negedge clk);
    check("single_ready", 32'(req_ready), 32'h4);
    check("single_busy_rise", 32'(busy), 32'd1);
    req_valid = 4'b0;
    @(negedge clk);
    check("single_start", 32'(tx_start), 32'd1);
    check("single_din", 32'(tx_din), 32'(first_word(2, 8'h5A)));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("single_din_hold", 32'(tx_din), 32'(first_word(2, 8'h5A)));
      check("single_start_pulse", 32'(tx_start), 32'd0);
    end
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
    serve(FRAMES - 1, 2);
    check("single_busy_fall", 32'(busy), 32'd0);
    check("single_grant_hold", 32'(grant_id), 32'd2);

    // Pointer now 3: search starts at 3, then wraps to 0
    issue(4'b1011, 3, 8'h44);
    issue(4'b0011, 0, 8'h11);

    // Spurious done in IDLE, in LOAD, and during the start pulse
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
    check("spur_idle_busy", 32'(busy), 32'd0);
    expect_word(1, 8'h22);
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = 4'b0;
    tx_done_tick = 1'b1;
    @(negedge clk);
    check("spur_start", 32'(tx_start), 32'd1);
    @(negedge clk);
    tx_done_tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("spur_still_waiting", 32'(busy), 32'd1);
    end
    finish_current(0);
    serve(FRAMES - 1, 2);
    check("spur_busy_fall", 32'(busy), 32'd0);

    // Reset during WAIT: in-flight word dropped, pointer back to 0
    exp_grant.push_back(2);
    exp_tx.push_back(first_word(2, 8'h5A));
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = 4'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_grant", 32'(grant_id), 32'd0);
    check("midrst_din", 32'(tx_din), 32'd0);
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
    check("midrst_stale_done", 32'(busy), 32'd0);
    issue(4'b1010, 1, 8'h22);

    // Requester 3 sends 8'h11 (tag 8'hA3 first when tagging is enabled)
    req_data[31:24] = 8'h11;
    issue(4'b1000, 3, 8'h11);

    repeat (5) @(negedge clk);
    check("sb_grants_drained", exp_grant.size(), 32'd0);
    check("sb_tx_drained", exp_tx.size(), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
